// File: rtl/f5_pkg.sv
// Shared types and constants for the f5 sweep checker slice.
package f5_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Golden truth table of f = a'.b: only minterm 1 (a=0, b=1) is true.
  localparam logic [3:0] F5_TT = 4'b0010;

  // Mismatch counter width: one extra bit so a count of 2**n fits.
  function automatic int CNT_W(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/f5_sweep_checker_if.sv
// Control and datapath bus between a test master and the sweep checker.
interface f5_sweep_checker_if #(
  parameter int N_IN = 2
) ();

  logic            start;
  logic            abort;
  logic [N_IN-1:0] stim;
  logic            resp_a;
  logic            resp_b;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   mismatch_cnt;
  logic [N_IN-1:0] fail_idx;
  logic            fail_valid;

  modport slave (
    input  start, abort, resp_a, resp_b,
    output stim, busy, done, pass, mismatch_cnt, fail_idx, fail_valid
  );

  modport master (
    output start, abort, resp_a, resp_b,
    input  stim, busy, done, pass, mismatch_cnt, fail_idx, fail_valid
  );

endinterface

// File: rtl/f5_stim_counter.sv
// Minterm counter that walks the stimulus bus through 0 .. 2**N_IN-1.
module f5_stim_counter #(
  parameter int N_IN = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            advance,
  output logic [N_IN-1:0] stim,
  output logic            last
);

  // Clear has priority so a sweep always restarts from minterm 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim <= '0;
    end else if (clear) begin
      stim <= '0;
    end else if (advance) begin
      stim <= stim + N_IN'(1);
    end
  end

  assign last = &stim;

endmodule

// File: rtl/f5_sweep_checker.sv
// Sweeps a small combinational datapath through every minterm, compares
// two implementations against each other and a golden table, and scores it.
module f5_sweep_checker
  import f5_pkg::*;
#(
  parameter int                   N_IN       = 2,
  parameter logic [2**N_IN-1:0]   EXP        = F5_TT,
  parameter int                   SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  f5_sweep_checker_if.slave bus
);

  localparam int CW = CNT_W(N_IN);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  state_t          state;
  state_t          state_nxt;
  logic [SW-1:0]   settle_cnt;
  logic [N_IN-1:0] stim;
  logic            last;
  logic            start_hit;
  logic            abort_hit;
  logic            sample_fire;
  logic            minterm_fail;
  logic            cnt_clear;
  logic            cnt_adv;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [CW-1:0]   mismatch_q;
  logic [N_IN-1:0] fail_idx_q;
  logic            fail_valid_q;

  f5_stim_counter #(.N_IN(N_IN)) u_stim_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .advance (cnt_adv),
    .stim    (stim),
    .last    (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the one-cycle control strobes; abort only matters mid-sweep.
  always_comb begin
    state_nxt   = state;
    start_hit   = 1'b0;
    abort_hit   = 1'b0;
    sample_fire = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = SETTLE;
          start_hit = 1'b1;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          abort_hit = 1'b1;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          abort_hit = 1'b1;
        end else begin
          sample_fire = 1'b1;
          state_nxt   = last ? DONE : SETTLE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign minterm_fail = (bus.resp_a != bus.resp_b) || (bus.resp_a != EXP[stim]);
  assign cnt_clear    = start_hit || abort_hit || (sample_fire && last);
  assign cnt_adv      = sample_fire && !last;

  // Settle timer: counts the hold cycles of the current minterm, idles at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (state == SETTLE && !bus.abort && settle_cnt != SETTLE_LAST) begin
      settle_cnt <= settle_cnt + SW'(1);
    end else begin
      settle_cnt <= '0;
    end
  end

  // Scoreboard and status: cleared on start, updated per sample, closed on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      mismatch_q   <= '0;
      fail_idx_q   <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_hit) begin
        busy_q       <= 1'b1;
        pass_q       <= 1'b0;
        mismatch_q   <= '0;
        fail_idx_q   <= '0;
        fail_valid_q <= 1'b0;
      end else if (abort_hit) begin
        busy_q <= 1'b0;
        pass_q <= 1'b0;
      end else if (sample_fire) begin
        if (minterm_fail) begin
          mismatch_q <= mismatch_q + CW'(1);
          if (!fail_valid_q) begin
            fail_idx_q   <= stim;
            fail_valid_q <= 1'b1;
          end
        end
        if (last) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          pass_q <= (mismatch_q == '0) && !minterm_fail;
        end
      end
    end
  end

  assign bus.stim         = stim;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.mismatch_cnt = mismatch_q;
  assign bus.fail_idx     = fail_idx_q;
  assign bus.fail_valid   = fail_valid_q;

endmodule
